// File: rtl/wb_result_collector.sv
// Write-back result collector.
// Buffers results from four execute-stage result ports (flu, load, store, fpu)
// in per-source FIFOs and serialises them onto one scoreboard write port
// using round-robin arbitration. A flush discards everything buffered.

package wb_result_collector_pkg;

  // Exception record carried alongside each result; stored verbatim.
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

endpackage

module wb_result_collector
  import wb_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     flu_valid_i,
  input  logic [TRANS_ID_BITS-1:0] flu_trans_id_i,
  input  logic [DATA_WIDTH-1:0]    flu_result_i,
  input  exception_t               flu_exception_i,
  input  logic                     load_valid_i,
  input  logic [TRANS_ID_BITS-1:0] load_trans_id_i,
  input  logic [DATA_WIDTH-1:0]    load_result_i,
  input  exception_t               load_exception_i,
  input  logic                     store_valid_i,
  input  logic [TRANS_ID_BITS-1:0] store_trans_id_i,
  input  logic [DATA_WIDTH-1:0]    store_result_i,
  input  exception_t               store_exception_i,
  input  logic                     fpu_valid_i,
  input  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i,
  input  logic [DATA_WIDTH-1:0]    fpu_result_i,
  input  exception_t               fpu_exception_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [DATA_WIDTH-1:0]    wb_result_o,
  output exception_t               wb_exception_o,
  input  logic                     wb_ready_i,
  output logic                     pending_o,
  output logic                     overflow_o
);

  localparam int NSRC = 4;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [DATA_WIDTH-1:0]    data;
    exception_t               ex;
  } entry_t;

  // Per-source FIFO state
  entry_t        storage_q [NSRC][DEPTH];
  logic [CW-1:0] count_q   [NSRC];
  logic [CW-1:0] count_d   [NSRC];
  logic [PW-1:0] rptr_q    [NSRC];
  logic [PW-1:0] rptr_d    [NSRC];
  logic [PW-1:0] wptr_q    [NSRC];
  logic [PW-1:0] wptr_d    [NSRC];
  logic [1:0]    rr_ptr_q;
  logic [1:0]    rr_ptr_d;
  logic          overflow_q;
  logic          overflow_d;

  // Combinational helpers
  logic [NSRC-1:0] src_valid_s;
  entry_t          src_entry_s [NSRC];
  logic [NSRC-1:0] nonempty_s;
  logic            grant_found_s;
  logic [1:0]      grant_idx_s;
  entry_t          head_s;
  logic            handshake_s;
  logic [NSRC-1:0] pop_s;
  logic [NSRC-1:0] accept_s;
  logic [NSRC-1:0] drop_s;

  // Gather the four result ports into indexable arrays (flu=0 .. fpu=3).
  always_comb begin
    src_valid_s    = {fpu_valid_i, store_valid_i, load_valid_i, flu_valid_i};
    src_entry_s[0] = '{id: flu_trans_id_i,   data: flu_result_i,   ex: flu_exception_i};
    src_entry_s[1] = '{id: load_trans_id_i,  data: load_result_i,  ex: load_exception_i};
    src_entry_s[2] = '{id: store_trans_id_i, data: store_result_i, ex: store_exception_i};
    src_entry_s[3] = '{id: fpu_trans_id_i,   data: fpu_result_i,   ex: fpu_exception_i};
  end

  // Round-robin pick of the first non-empty FIFO at or after rr_ptr.
  always_comb begin
    logic [1:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      nonempty_s[k] = (count_q[k] != CW'(0));
    end
    for (int i = 0; i < NSRC; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!grant_found_s && nonempty_s[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Drive write-back port from the granted head; flush masks valid.
  always_comb begin
    head_s         = storage_q[grant_idx_s][rptr_q[grant_idx_s]];
    wb_valid_o     = grant_found_s & ~flush_i;
    wb_trans_id_o  = head_s.id;
    wb_result_o    = head_s.data;
    wb_exception_o = head_s.ex;
    handshake_s    = wb_valid_o & wb_ready_i;
    pending_o      = |nonempty_s;
    overflow_o     = overflow_q;
  end

  // Push/pop decisions; a full FIFO still accepts when popped the same cycle.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      pop_s[k]    = handshake_s & (grant_idx_s == 2'(k));
      accept_s[k] = src_valid_s[k] & ~flush_i &
                    ((count_q[k] < CW'(DEPTH)) | pop_s[k]);
      drop_s[k]   = src_valid_s[k] & ~flush_i & ~accept_s[k];
    end
  end

  // Next-state for pointers, counts, arbitration pointer and sticky overflow.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q | (|drop_s);
    for (int k = 0; k < NSRC; k++) begin
      count_d[k] = count_q[k];
      rptr_d[k]  = rptr_q[k];
      wptr_d[k]  = wptr_q[k];
    end
    if (flush_i) begin
      rr_ptr_d = 2'd0;
      for (int k = 0; k < NSRC; k++) begin
        count_d[k] = CW'(0);
        rptr_d[k]  = PW'(0);
        wptr_d[k]  = PW'(0);
      end
    end else begin
      if (handshake_s) begin
        rr_ptr_d = grant_idx_s + 2'd1;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      for (int k = 0; k < NSRC; k++) begin
        count_d[k] = count_q[k] + CW'(accept_s[k]) - CW'(pop_s[k]);
        rptr_d[k]  = pop_s[k]    ? rptr_q[k] + PW'(1) : rptr_q[k];
        wptr_d[k]  = accept_s[k] ? wptr_q[k] + PW'(1) : wptr_q[k];
      end
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= 2'd0;
      overflow_q <= 1'b0;
      for (int k = 0; k < NSRC; k++) begin
        count_q[k] <= CW'(0);
        rptr_q[k]  <= PW'(0);
        wptr_q[k]  <= PW'(0);
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < NSRC; k++) begin
        count_q[k] <= count_d[k];
        rptr_q[k]  <= rptr_d[k];
        wptr_q[k]  <= wptr_d[k];
      end
    end
  end

  // Entry storage; written on accepted pushes only, never reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NSRC; k++) begin
      if (accept_s[k]) begin
        storage_q[k][wptr_q[k]] <= src_entry_s[k];
      end
    end
  end

endmodule

// File: tb/tb_wb_result_collector.sv
// Self-checking bench for wb_result_collector: per-source scoreboard queues
// with a round-robin reference pick, compared against the write-back port.

module tb_wb_result_collector;
  import wb_result_collector_pkg::*;

  localparam int DW    = 64;
  localparam int IDW   = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    exception_t     ex;
  } ent_t;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           wb_ready;
  logic           vld [4];
  ent_t           ent [4];
  logic           wb_valid;
  logic [IDW-1:0] wb_id;
  logic [DW-1:0]  wb_data;
  exception_t     wb_ex;
  logic           pending;
  logic           overflow;

  int   n_chk;
  int   n_err;
  ent_t sb_q [4][$];
  int   m_rr;
  bit   m_ovf;

  wb_result_collector #(.DATA_WIDTH(DW), .TRANS_ID_BITS(IDW), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .flu_valid_i      (vld[0]),
    .flu_trans_id_i   (ent[0].id),
    .flu_result_i     (ent[0].data),
    .flu_exception_i  (ent[0].ex),
    .load_valid_i     (vld[1]),
    .load_trans_id_i  (ent[1].id),
    .load_result_i    (ent[1].data),
    .load_exception_i (ent[1].ex),
    .store_valid_i    (vld[2]),
    .store_trans_id_i (ent[2].id),
    .store_result_i   (ent[2].data),
    .store_exception_i(ent[2].ex),
    .fpu_valid_i      (vld[3]),
    .fpu_trans_id_i   (ent[3].id),
    .fpu_result_i     (ent[3].data),
    .fpu_exception_i  (ent[3].ex),
    .wb_valid_o       (wb_valid),
    .wb_trans_id_o    (wb_id),
    .wb_result_o      (wb_data),
    .wb_exception_o   (wb_ex),
    .wb_ready_i       (wb_ready),
    .pending_o        (pending),
    .overflow_o       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
    end
    m_rr = 0;
  endtask

  // Drive one result on source k for the next edge.
  task automatic drive(input int k, input logic [IDW-1:0] id, input logic [DW-1:0] data);
    vld[k]          = 1'b1;
    ent[k].id       = id;
    ent[k].data     = data;
    ent[k].ex.cause = {$urandom, $urandom};
    ent[k].ex.tval  = {$urandom, $urandom};
    ent[k].ex.valid = 1'($urandom_range(0, 1));
  endtask

  // Check outputs for the current cycle, advance one edge, update the model.
  task automatic step();
    bit   any;
    int   g;
    ent_t e;
    #1;
    any = 1'b0;
    g   = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_rr + i) % 4;
      if (!any && sb_q[c].size() > 0) begin
        any = 1'b1;
        g   = c;
      end
    end
    check_eq("pending", 192'(pending), 192'(any));
    check_eq("wb_valid", 192'(wb_valid), 192'(any && !flush));
    if (any && !flush) begin
      e = sb_q[g][0];
      check_eq("wb_id", 192'(wb_id), 192'(e.id));
      check_eq("wb_data", 192'(wb_data), 192'(e.data));
      check_eq("wb_ex", 192'(wb_ex), 192'(e.ex));
    end
    @(posedge clk);
    if (flush) begin
      clear_model();
    end else begin
      if (any && wb_ready) begin
        void'(sb_q[g].pop_front());
        m_rr = (g + 1) % 4;
      end
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) begin
          if (sb_q[k].size() < DEPTH) sb_q[k].push_back(ent[k]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
    check_eq("overflow", 192'(overflow), 192'(m_ovf));
    clear_inputs();
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    m_ovf    = 1'b0;
    rst_n    = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ent[k] = '0;
    end
    clear_inputs();
    clear_model();
    #1;
    check_eq("rst_valid", 192'(wb_valid), 192'(0));
    check_eq("rst_pending", 192'(pending), 192'(0));
    check_eq("rst_overflow", 192'(overflow), 192'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single FLU result with 1-cycle latency, then empty.
    drive(0, 3'd5, 64'hDEAD);
    step();
    step();
    step();

    // Flush an empty collector to bring the arbitration pointer back to 0.
    flush = 1'b1;
    step();

    // All four sources at once drain in order 0,1,2,3.
    drive(0, 3'd1, 64'h11);
    drive(1, 3'd2, 64'h22);
    drive(2, 3'd3, 64'h33);
    drive(3, 3'd4, 64'h44);
    step();
    repeat (5) step();

    // Stalled grant keeps the load entry stable, then one handshake.
    wb_ready = 1'b0;
    drive(1, 3'd2, 64'hBEEF);
    step();
    repeat (3) step();
    wb_ready = 1'b1;
    step();
    step();

    // Full FPU FIFO with simultaneous pop and push: no overflow, order kept.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3, 3'(i), 64'(i + 16'h100));
      step();
    end
    wb_ready = 1'b1;
    drive(3, 3'd4, 64'h104);
    step();
    repeat (5) step();

    // Five pulses into a 4-deep FIFO while stalled: fifth one dropped.
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3, 3'(i), 64'(i + 16'h200));
      step();
    end
    wb_ready = 1'b1;
    repeat (6) step();

    // Flush with three entries buffered and a same-cycle store pulse.
    wb_ready = 1'b0;
    drive(0, 3'd6, 64'h600);
    drive(1, 3'd7, 64'h700);
    drive(2, 3'd0, 64'h800);
    step();
    flush = 1'b1;
    drive(2, 3'd1, 64'h900);
    step();
    wb_ready = 1'b1;
    step();

    // Random traffic with random backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 99) < 40) drive(k, 3'($urandom), {$urandom, $urandom});
      end
      wb_ready = ($urandom_range(0, 99) < 60);
      flush    = ($urandom_range(0, 99) < 4);
      step();
    end

    // Asynchronous reset mid-operation clears state immediately.
    wb_ready = 1'b0;
    drive(0, 3'd2, 64'h1);
    drive(3, 3'd3, 64'h2);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 192'(wb_valid), 192'(0));
    check_eq("midrst_pending", 192'(pending), 192'(0));
    check_eq("midrst_overflow", 192'(overflow), 192'(0));
    clear_model();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    drive(2, 3'd5, 64'hCAFE);
    step();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
